rfsc_peak_select: RTL and testbench
===================================

Name: rfsc_peak_select

Overview:
- Sits directly downstream of the RFSC state machine and consumes its eight 11-bit accumulators AC1..AC8 and its `update` strobe.
- On each update, it takes a snapshot of all eight accumulators and scans them serially over 8 cycles to find the channel with the largest value.
- It publishes the winning index and value, a below-threshold flag and a one-cycle valid pulse to the display/LED logic.

Parameters:
- AC_W, 11, accumulator width.
- N_CH, 8, number of channels (fixed at 8; index width 3).
- THRESH, 11'd64, minimum peak value treated as a real signal.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- EN  in  1  enable; when low, update strobes are ignored.
- update  in  1  one-cycle strobe from the RFSC core: AC1..AC8 are valid.
- AC1..AC8  in  11 each  channel accumulators.
- busy  out  1  high while a snapshot is being scanned.
- peak_valid  out  1  one-cycle pulse when results change.
- peak_idx  out  3  winning channel, 0 = AC1 .. 7 = AC8.
- peak_val  out  11  winning accumulator value.
- no_signal  out  1  peak_val < THRESH, registered with peak_val.
- overrun  out  1  sticky: an update arrived while busy.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state = IDLE; busy = 0; peak_valid = 0;
  - peak_idx = 0; peak_val = 0; no_signal = 1; overrun = 0;
  - snapshot registers and scan counter = 0.
- States: IDLE, SCAN, DONE.
- IDLE: if update && EN at edge N:
  - snapshot AC1..AC8 into snap[0..7];
  - cnt <= 0; best_val <= 0; best_idx <= 0; state <= SCAN.
- SCAN, edges N+1..N+8: if snap[cnt] > best_val (strictly greater), then best_val <= snap[cnt] and best_idx <= cnt.
  - cnt increments each edge.
  - At cnt == 7, state <= DONE.
- DONE, edge N+9: peak_idx <= best_idx; peak_val <= best_val; no_signal <= (best_val < THRESH); peak_valid <= 1; state <= IDLE.
- peak_valid is high only during the cycle between edges N+9 and N+10; it is cleared at the next edge.
- busy is 1 in SCAN and DONE, 0 in IDLE.
- Latency: the result appears 9 edges after the edge that samples update.
  - The earliest next update is accepted at edge N+10, i.e. while peak_valid is high; that is legal.
- Ties: the lowest index wins, because the comparison is strictly greater.
  - All-zero input gives idx 0, val 0, no_signal 1.
- Unsigned arithmetic, 11-bit compares only, no overflow path.
- update while busy: ignored and the scan is not restarted; overrun <= 1 (sticky until Reset).
- update with EN low: ignored, overrun not set.
- EN dropping mid-scan: the scan completes normally.
- Changes on AC1..AC8 after the snapshot edge do not affect the result.
- Reset asserted mid-scan: immediate return to the reset values; no peak_valid pulse is emitted.
- peak_idx, peak_val and no_signal hold their last values between results.

Optional Feature:
- Macro: RFSC_PEAK_HOLD_EN.
- Defined:
  - adds input hold_clr (1 bit);
  - DONE updates peak_idx/peak_val/no_signal only if best_val > the current peak_val (max-hold);
  - peak_valid pulses only when the held value changes;
  - hold_clr high at an edge clears peak_val to 0, peak_idx to 0 and no_signal to 1;
  - if hold_clr coincides with DONE, the clear is applied first, so the new result is loaded.
- Undefined: no hold_clr port; every DONE loads the result and pulses peak_valid.

Decomposition:
- Package rfsc_pkg holds:
  - AC_W = 11, N_CH = 8, IDX_W = 3;
  - the state enum {IDLE, SCAN, DONE};
  - the default THRESH constant.
- One natural sub-module: rfsc_max_step, a combinational compare/select of (cand_val, cand_idx) against (best_val, best_idx). It returns the new best using the strictly-greater rule and is reusable by a future parallel-tree variant.

Test Plan:
- AC1..AC8 = 10,20,30,700,40,50,60,70, pulse update → 9 edges later peak_valid = 1 for 1 cycle, peak_idx = 3, peak_val = 700, no_signal = 0.
- All AC = 5 → peak_idx = 0, peak_val = 5, no_signal = 1 (5 < 64).
- AC3 = AC7 = 2047, others 0 → peak_idx = 2, peak_val = 2047 (tie, lowest index wins).
- update again 3 cycles into a scan → result unchanged from the first snapshot, overrun = 1 and stays 1; a back-to-back update during the peak_valid cycle is accepted.
- Change AC inputs the cycle after update → result reflects the snapshot values only.
- Reset low during SCAN → all outputs at reset values immediately, no peak_valid; EN = 0 with update → no activity.
- With RFSC_PEAK_HOLD_EN defined: peak 700 then peak 300 → peak_val stays 700 with no second pulse; hold_clr, then 300 → peak_val = 300.

Source files
------------

// File: rtl/rfsc_pkg.sv
// Shared constants and state encoding for the RFSC peak selector.
package rfsc_pkg;

    localparam int AC_W  = 11;
    localparam int N_CH  = 8;
    localparam int IDX_W = 3;

    localparam logic [AC_W-1:0] THRESH_DEF = 11'd64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rfsc_max_step.sv
// One compare/select step: the candidate replaces the best only if strictly
// greater, so the earliest (lowest index) of equal values is kept.
module rfsc_max_step
    import rfsc_pkg::*;
(
    input  logic [AC_W-1:0]  cand_val,
    input  logic [IDX_W-1:0] cand_idx,
    input  logic [AC_W-1:0]  best_val,
    input  logic [IDX_W-1:0] best_idx,
    output logic [AC_W-1:0]  new_val,
    output logic [IDX_W-1:0] new_idx
);

    logic take;

    assign take    = cand_val > best_val;
    assign new_val = take ? cand_val : best_val;
    assign new_idx = take ? cand_idx : best_idx;

endmodule

// File: rtl/rfsc_peak_select.sv
// Snapshots AC1..AC8 on update and scans them serially for the peak channel.
// Define RFSC_PEAK_HOLD_EN for max-hold outputs with a hold_clr input.
module rfsc_peak_select
    import rfsc_pkg::*;
#(
    parameter logic [AC_W-1:0] THRESH = THRESH_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             EN,
    input  logic             update,
`ifdef RFSC_PEAK_HOLD_EN
    input  logic             hold_clr,
`endif
    input  logic [AC_W-1:0]  AC1,
    input  logic [AC_W-1:0]  AC2,
    input  logic [AC_W-1:0]  AC3,
    input  logic [AC_W-1:0]  AC4,
    input  logic [AC_W-1:0]  AC5,
    input  logic [AC_W-1:0]  AC6,
    input  logic [AC_W-1:0]  AC7,
    input  logic [AC_W-1:0]  AC8,
    output logic             busy,
    output logic             peak_valid,
    output logic [IDX_W-1:0] peak_idx,
    output logic [AC_W-1:0]  peak_val,
    output logic             no_signal,
    output logic             overrun
);

    state_t            state_q;
    logic [AC_W-1:0]   snap_q [N_CH];
    logic [IDX_W-1:0]  cnt_q;
    logic [AC_W-1:0]   best_val_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [AC_W-1:0]   best_val_d;
    logic [IDX_W-1:0]  best_idx_d;
    logic              valid_q;
    logic [IDX_W-1:0]  idx_q;
    logic [AC_W-1:0]   val_q;
    logic              nosig_q;
    logic              ovr_q;
    logic              start;
    logic              load;

    assign start = update && EN;

    rfsc_max_step u_step (
        .cand_val (snap_q[cnt_q]),
        .cand_idx (cnt_q),
        .best_val (best_val_q),
        .best_idx (best_idx_q),
        .new_val  (best_val_d),
        .new_idx  (best_idx_d)
    );

`ifdef RFSC_PEAK_HOLD_EN
    // A coincident clear is applied first, so compare against zero then.
    assign load = best_val_q > (hold_clr ? '0 : val_q);
`else
    assign load = 1'b1;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            val_q      <= '0;
            nosig_q    <= 1'b1;
            ovr_q      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (start && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end
`ifdef RFSC_PEAK_HOLD_EN
            if (hold_clr) begin
                idx_q   <= '0;
                val_q   <= '0;
                nosig_q <= 1'b1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q[0]  <= AC1;
                        snap_q[1]  <= AC2;
                        snap_q[2]  <= AC3;
                        snap_q[3]  <= AC4;
                        snap_q[4]  <= AC5;
                        snap_q[5]  <= AC6;
                        snap_q[6]  <= AC7;
                        snap_q[7]  <= AC8;
                        cnt_q      <= '0;
                        best_val_q <= '0;
                        best_idx_q <= '0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    best_val_q <= best_val_d;
                    best_idx_q <= best_idx_d;
                    cnt_q      <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (load) begin
                        idx_q   <= best_idx_q;
                        val_q   <= best_val_q;
                        nosig_q <= best_val_q < THRESH;
                        valid_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = state_q != IDLE;
    assign peak_valid = valid_q;
    assign peak_idx   = idx_q;
    assign peak_val   = val_q;
    assign no_signal  = nosig_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_rfsc_peak_select.sv
// Directed scoreboard bench for rfsc_peak_select (optionally RFSC_PEAK_HOLD_EN).
module tb_rfsc_peak_select;

    typedef struct {
        logic [2:0]  idx;
        logic [10:0] val;
        logic        ns;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        EN = 1'b1;
    logic        update = 1'b0;
    logic        hold_clr = 1'b0;
    logic [10:0] ac [8];
    logic        busy;
    logic        peak_valid;
    logic [2:0]  peak_idx;
    logic [10:0] peak_val;
    logic        no_signal;
    logic        overrun;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 Clk = ~Clk;

    rfsc_peak_select dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .EN         (EN),
        .update     (update),
`ifdef RFSC_PEAK_HOLD_EN
        .hold_clr   (hold_clr),
`endif
        .AC1        (ac[0]),
        .AC2        (ac[1]),
        .AC3        (ac[2]),
        .AC4        (ac[3]),
        .AC5        (ac[4]),
        .AC6        (ac[5]),
        .AC7        (ac[6]),
        .AC8        (ac[7]),
        .busy       (busy),
        .peak_valid (peak_valid),
        .peak_idx   (peak_idx),
        .peak_val   (peak_val),
        .no_signal  (no_signal),
        .overrun    (overrun)
    );

    function automatic exp_t model();
        exp_t e;
        e.idx = 3'd0;
        e.val = 11'd0;
        for (int i = 0; i < 8; i++) begin
            if (ac[i] > e.val) begin
                e.val = ac[i];
                e.idx = 3'(i);
            end
        end
        e.ns = e.val < 11'd64;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ac(input int a0, a1, a2, a3, a4, a5, a6, a7);
        ac[0] = 11'(a0); ac[1] = 11'(a1); ac[2] = 11'(a2); ac[3] = 11'(a3);
        ac[4] = 11'(a4); ac[5] = 11'(a5); ac[6] = 11'(a6); ac[7] = 11'(a7);
    endtask

    task automatic start(input bit push);
        update = 1'b1;
        step();
        update = 1'b0;
        if (push) sb.push_back(model());
    endtask

    task automatic clr_hold();
`ifdef RFSC_PEAK_HOLD_EN
        hold_clr = 1'b1;
        step();
        hold_clr = 1'b0;
`endif
    endtask

    task automatic wait_result(input string tag, input int lat);
        int n = 0;
        bit got = 0;
        exp_t e;
        while (!got && n < lat + 4) begin
            step();
            n++;
            if (peak_valid === 1'b1) got = 1;
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
        if (got) chk({tag, "_lat"}, n, lat);
        if (sb.size() == 0) begin
            chk({tag, "_sb"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_idx"}, 32'(peak_idx), 32'(e.idx));
            chk({tag, "_val"}, 32'(peak_val), 32'(e.val));
            chk({tag, "_ns"}, 32'(no_signal), 32'(e.ns));
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit seen = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (peak_valid !== 1'b0) seen = 1;
        end
        chk({tag, "_nopulse"}, 32'(seen), 32'd0);
    endtask

    initial begin
        set_ac(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pv", 32'(peak_valid), 32'd0);
        chk("rst_idx", 32'(peak_idx), 32'd0);
        chk("rst_val", 32'(peak_val), 32'd0);
        chk("rst_ns", 32'(no_signal), 32'd1);
        chk("rst_ovr", 32'(overrun), 32'd0);
        Reset = 1'b1;
        step();

        set_ac(10, 20, 30, 700, 40, 50, 60, 70);
        start(1);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_result("t1", 9);
        step();
        chk("t1_pvclr", 32'(peak_valid), 32'd0);
        chk("t1_hold", 32'(peak_val), 32'd700);

        clr_hold();
        set_ac(5, 5, 5, 5, 5, 5, 5, 5);
        start(1);
        wait_result("t2", 9);

        clr_hold();
        set_ac(0, 0, 2047, 0, 0, 0, 2047, 0);
        start(1);
        wait_result("t3", 9);

        clr_hold();
        set_ac(100, 200, 300, 400, 450, 500, 120, 80);
        start(1);
        repeat (3) step();
        set_ac(2000, 0, 0, 0, 0, 0, 0, 0);
        start(0);
        chk("t4_ovr", 32'(overrun), 32'd1);
        wait_result("t4", 5);
        chk("t4_ovr2", 32'(overrun), 32'd1);

        set_ac(1, 2, 3, 4, 5, 6, 1500, 8);
        start(1);
        chk("t4b_pvclr", 32'(peak_valid), 32'd0);
        chk("t4b_busy", 32'(busy), 32'd1);
        wait_result("t4b", 9);
        step();

        clr_hold();
        set_ac(90, 80, 70, 60, 950, 40, 30, 20);
        start(1);
        set_ac(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047);
        wait_result("t5", 9);
        step();

        clr_hold();
        set_ac(10, 20, 30, 40, 1000, 60, 70, 80);
        start(1);
        repeat (3) step();
        Reset = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pv", 32'(peak_valid), 32'd0);
        chk("t6_idx", 32'(peak_idx), 32'd0);
        chk("t6_val", 32'(peak_val), 32'd0);
        chk("t6_ns", 32'(no_signal), 32'd1);
        chk("t6_ovr", 32'(overrun), 32'd0);
        #3;
        Reset = 1'b1;
        quiet("t6", 12);

        EN = 1'b0;
        start(0);
        chk("t7_busy", 32'(busy), 32'd0);
        quiet("t7", 12);
        chk("t7_ovr", 32'(overrun), 32'd0);
        EN = 1'b1;

`ifdef RFSC_PEAK_HOLD_EN
        clr_hold();
        set_ac(10, 20, 30, 700, 40, 50, 60, 70);
        start(1);
        wait_result("h1", 9);
        set_ac(10, 300, 30, 40, 40, 50, 60, 70);
        start(0);
        quiet("h2", 12);
        chk("h2_val", 32'(peak_val), 32'd700);
        chk("h2_idx", 32'(peak_idx), 32'd3);
        clr_hold();
        chk("h3_val", 32'(peak_val), 32'd0);
        chk("h3_idx", 32'(peak_idx), 32'd0);
        chk("h3_ns", 32'(no_signal), 32'd1);
        start(1);
        wait_result("h4", 9);
`endif

        chk("end_sb", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
